// File: rtl/y86_pkg.sv
// y86_pkg -- shared constants and helpers for the SEQ Y86-64 controller.
//   icode constants (I_*), processor status codes (S_*), controller state
//   encoding (state_e), the per-stage enable bundle (en_t) and decode helpers.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'd0;
  localparam logic [3:0] I_NOP    = 4'd1;
  localparam logic [3:0] I_RRMOVQ = 4'd2;
  localparam logic [3:0] I_IRMOVQ = 4'd3;
  localparam logic [3:0] I_RMMOVQ = 4'd4;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_OPQ    = 4'd6;
  localparam logic [3:0] I_JXX    = 4'd7;
  localparam logic [3:0] I_CALL   = 4'd8;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_PUSHQ  = 4'd10;
  localparam logic [3:0] I_POPQ   = 4'd11;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  // Bit 3 only distinguishes the single-step wait from IDLE; the visible
  // stage code is the low three bits, so STEP reads back as 0.
  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_EXECUTE = 4'd3,
    ST_MEMORY  = 4'd4,
    ST_WBACK   = 4'd5,
    ST_PCUPD   = 4'd6,
    ST_HALT    = 4'd7,
    ST_STEP    = 4'd8
  } state_e;

  typedef struct packed {
    logic fetch;
    logic decode;
    logic exec;
    logic set_cc;
    logic mem;
    logic wb;
    logic pc;
  } en_t;

  function automatic logic uses_mem(input logic [3:0] ic);
    return ic inside {I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ};
  endfunction

  function automatic logic writes_reg(input logic [3:0] ic);
    return ic inside {I_RRMOVQ, I_IRMOVQ, I_MRMOVQ, I_OPQ,
                      I_CALL, I_RET, I_PUSHQ, I_POPQ};
  endfunction

  // Stage enables for the state being entered, so they can be registered.
  function automatic en_t stage_en(input state_e st, input logic [3:0] ic);
    en_t e;
    e = '0;
    case (st)
      ST_FETCH:   e.fetch  = 1'b1;
      ST_DECODE:  e.decode = 1'b1;
      ST_EXECUTE: begin
        e.exec   = 1'b1;
        e.set_cc = (ic == I_OPQ);
      end
      ST_MEMORY:  e.mem = uses_mem(ic);
      ST_WBACK:   e.wb  = writes_reg(ic);
      ST_PCUPD:   e.pc  = 1'b1;
      default:    ;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer -- counts MEMORY-stage cycles spent without dmem_ready.
//   clk, rst    : clock, async active-high reset
//   i_clr       : clear count (outside MEMORY)
//   i_en        : count this cycle (waiting, no ready)
//   o_timeout   : this waiting cycle brings the count to MEM_TIMEOUT
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_timeout
);

  localparam int W = $clog2(MEM_TIMEOUT + 1);

  logic [W-1:0] r_cnt;

  // Combinational so the FSM can leave MEMORY on the very cycle the limit
  // is reached.
  assign o_timeout = i_en && (r_cnt == W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/seq_stage_ctrl.sv
// seq_stage_ctrl -- multi-cycle stage sequencer for the SEQ Y86-64 datapath.
//   Steps FETCH, DECODE, EXECUTE, MEMORY, WBACK, PCUPD with one stage enable
//   per cycle, stretches MEMORY until dmem_ready (bounded by MEM_TIMEOUT),
//   and reports halt / invalid-instruction / address faults on o_stat.
// Ports:
//   clk, rst             clock, async active-high reset
//   i_start              leave IDLE (sampled in IDLE only)
//   i_icode              icode from fetch, captured in DECODE
//   i_imem_error         imem fault, sampled in FETCH
//   i_dmem_ready/_error  dmem handshake, sampled in MEMORY
//   i_step               resume from STEP (only with SEQ_SINGLE_STEP_EN)
//   o_*_en, o_set_cc     registered stage enables
//   o_stage, o_stat      state code, status (1 AOK 2 HLT 3 ADR 4 INS)
//   o_busy               high outside IDLE/HALT/STEP
//   o_instr_count        retired instructions, wraps
// Optional macro: SEQ_SINGLE_STEP_EN adds i_step and the STEP wait state.
module seq_stage_ctrl
  import y86_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [3:0]       i_icode,
  input  logic             i_imem_error,
  input  logic             i_dmem_ready,
  input  logic             i_dmem_error,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic             i_step,
`endif
  output logic             o_fetch_en,
  output logic             o_decode_en,
  output logic             o_exec_en,
  output logic             o_set_cc,
  output logic             o_mem_en,
  output logic             o_wb_en,
  output logic             o_pc_en,
  output logic [2:0]       o_stage,
  output logic [2:0]       o_stat,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_instr_count
);

  state_e           r_state, w_nxt;
  logic [3:0]       r_icode, w_icode;
  logic [2:0]       r_stat, w_stat;
  en_t              r_en;
  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic             w_wait, w_timeout;

  // Capture icode on the DECODE edge; later stages use the registered copy.
  assign w_icode = (r_state == ST_DECODE) ? i_icode : r_icode;
  assign w_wait  = (r_state == ST_MEMORY) && uses_mem(r_icode) && !i_dmem_ready;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (r_state != ST_MEMORY),
    .i_en      (w_wait),
    .o_timeout (w_timeout)
  );

  always_comb begin
    w_nxt  = r_state;
    w_stat = r_stat;
    case (r_state)
      ST_IDLE:    if (i_start) w_nxt = ST_FETCH;
      ST_FETCH:   if (i_imem_error) begin
                    w_nxt  = ST_HALT;
                    w_stat = S_ADR;
                  end else w_nxt = ST_DECODE;
      ST_DECODE:  if (i_icode == I_HALT) begin
                    w_nxt  = ST_HALT;
                    w_stat = S_HLT;
                  end else if (i_icode > I_POPQ) begin
                    w_nxt  = ST_HALT;
                    w_stat = S_INS;
                  end else w_nxt = ST_EXECUTE;
      ST_EXECUTE: w_nxt = ST_MEMORY;
      ST_MEMORY:  if (!uses_mem(r_icode)) w_nxt = ST_WBACK;
                  else if (i_dmem_ready) begin
                    // ready beats a same-cycle timeout
                    w_nxt  = i_dmem_error ? ST_HALT : ST_WBACK;
                    w_stat = i_dmem_error ? S_ADR : r_stat;
                  end else if (w_timeout) begin
                    w_nxt  = ST_HALT;
                    w_stat = S_ADR;
                  end
      ST_WBACK:   w_nxt = ST_PCUPD;
`ifdef SEQ_SINGLE_STEP_EN
      ST_PCUPD:   w_nxt = ST_STEP;
      ST_STEP:    if (i_step) w_nxt = ST_FETCH;
`else
      ST_PCUPD:   w_nxt = ST_FETCH;
`endif
      default:    ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_icode <= '0;
      r_stat  <= S_AOK;
      r_en    <= '0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      r_icode <= w_icode;
      r_stat  <= w_stat;
      r_en    <= stage_en(w_nxt, w_icode);
      r_busy  <= !(w_nxt inside {ST_IDLE, ST_HALT, ST_STEP});
      if (r_state == ST_PCUPD) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_fetch_en    = r_en.fetch;
  assign o_decode_en   = r_en.decode;
  assign o_exec_en     = r_en.exec;
  assign o_set_cc      = r_en.set_cc;
  assign o_mem_en      = r_en.mem;
  assign o_wb_en       = r_en.wb;
  assign o_pc_en       = r_en.pc;
  assign o_stage       = r_state[2:0];
  assign o_stat        = r_stat;
  assign o_busy        = r_busy;
  assign o_instr_count = r_cnt;

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// tb_seq_stage_ctrl -- directed bench for seq_stage_ctrl.
//   A trace model expands each instruction into the per-cycle outputs the
//   stage rules require, together with the inputs to drive on each cycle;
//   every cycle of the trace is compared. Literal pins check cycle counts,
//   final counts and status codes. Honors SEQ_SINGLE_STEP_EN.
module tb_seq_stage_ctrl;

  localparam int TO = 15;
  localparam int CW = 3;   // narrow counter so wrap is reachable

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0, ie = 1'b0, rdy = 1'b0, derr = 1'b0;
  logic [3:0]    ic = 4'd0;
`ifdef SEQ_SINGLE_STEP_EN
  logic          step = 1'b0;
`endif
  logic          o_fetch_en, o_decode_en, o_exec_en, o_set_cc, o_mem_en, o_wb_en, o_pc_en;
  logic [2:0]    o_stage, o_stat;
  logic          o_busy;
  logic [CW-1:0] o_instr_count;

  seq_stage_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_icode(ic),
    .i_imem_error(ie), .i_dmem_ready(rdy), .i_dmem_error(derr),
`ifdef SEQ_SINGLE_STEP_EN
    .i_step(step),
`endif
    .o_fetch_en(o_fetch_en), .o_decode_en(o_decode_en), .o_exec_en(o_exec_en),
    .o_set_cc(o_set_cc), .o_mem_en(o_mem_en), .o_wb_en(o_wb_en), .o_pc_en(o_pc_en),
    .o_stage(o_stage), .o_stat(o_stat), .o_busy(o_busy), .o_instr_count(o_instr_count)
  );

  // en order: fetch decode exec set_cc mem wb pc
  typedef struct {
    logic       start, ie, rdy, derr, step;
    logic [3:0] ic;
    logic [2:0] stg;
    logic [6:0] en;
    logic [2:0] st;
    logic       busy;
    int         cnt;
  } ent_t;

  ent_t plan[$];
  int nvec = 0, nfail = 0;
  int obs_mem = 0, obs_wb = 0, obs_pc = 0, obs_cc = 0, obs_busy = 0;

  int         m_cnt;
  logic [2:0] m_stat;
  bit         m_halted, m_need_step;
  logic       p_start, p_ie, p_rdy, p_derr, p_step;
  logic [3:0] p_ic;

  function automatic bit mem_op(input logic [3:0] c);
    return c inside {4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11};
  endfunction
  function automatic bit wr_op(input logic [3:0] c);
    return c inside {4'd2, 4'd3, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] stg, input logic [6:0] en);
    ent_t e;
    e.start = p_start; e.ie = p_ie; e.rdy = p_rdy; e.derr = p_derr; e.step = p_step;
    e.ic = p_ic; e.stg = stg; e.en = en; e.st = m_stat;
    e.busy = !(stg == 3'd0 || stg == 3'd7);
    e.cnt = m_cnt;
    plan.push_back(e);
  endtask

  task automatic halt_with(input logic [2:0] s);
    m_stat = s;
    m_halted = 1'b1;
  endtask

  task automatic add_idle();
    p_start = 1'b1; p_ie = 1'b0; p_rdy = 1'b0; p_derr = 1'b0; p_step = 1'b0; p_ic = 4'd0;
    push(3'd0, 7'b0);
  endtask

  // dly: MEMORY cycle (from 0) on which dmem_ready arrives; <0 = never
  task automatic add_instr(input logic [3:0] c, input logic e_im, input int dly, input logic e_dm);
    bit done;
    if (m_halted) return;
    p_start = 1'b0; p_ic = c; p_ie = e_im; p_derr = e_dm; p_step = 1'b0;
    p_rdy = !mem_op(c);
`ifdef SEQ_SINGLE_STEP_EN
    if (m_need_step) begin
      push(3'd0, 7'b0);
      push(3'd0, 7'b0);
      p_step = 1'b1;
      push(3'd0, 7'b0);
      p_step = 1'b0;
    end
`endif
    push(3'd1, 7'b1000000);
    if (e_im) begin halt_with(3'd3); return; end
    push(3'd2, 7'b0100000);
    if (c == 4'd0) begin halt_with(3'd2); return; end
    if (c > 4'd11) begin halt_with(3'd4); return; end
    push(3'd3, {3'b001, (c == 4'd6), 3'b000});
    if (mem_op(c)) begin
      done = 1'b0;
      for (int w = 0; w < TO && !done; w++) begin
        p_rdy = (w == dly);
        push(3'd4, 7'b0000100);
        if (p_rdy) begin
          if (e_dm) begin halt_with(3'd3); return; end
          done = 1'b1;
        end else if (w == TO - 1) begin
          halt_with(3'd3);
          return;
        end
      end
      p_rdy = 1'b0;
    end else begin
      push(3'd4, 7'b0);
    end
    push(3'd5, {5'b0, wr_op(c), 1'b0});
    push(3'd6, 7'b0000001);
    m_cnt = (m_cnt + 1) % (1 << CW);
    m_need_step = 1'b1;
  endtask

  // Cycles after the last instruction: HALT with start pulsed, or STEP idle.
  task automatic add_tail(input int n);
    p_start = m_halted;
    p_step = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (m_halted) push(3'd7, 7'b0);
`ifdef SEQ_SINGLE_STEP_EN
      else push(3'd0, 7'b0);
`endif
    end
    p_start = 1'b0;
  endtask

  task automatic drive(input ent_t e);
    start = e.start; ie = e.ie; rdy = e.rdy; derr = e.derr; ic = e.ic;
`ifdef SEQ_SINGLE_STEP_EN
    step = e.step;
`endif
  endtask

  task automatic check_cycle(input int k, input ent_t e);
    check($sformatf("cyc%0d stg/en/stat/busy/cnt", k),
          {o_stage, o_fetch_en, o_decode_en, o_exec_en, o_set_cc, o_mem_en, o_wb_en,
           o_pc_en, o_stat, o_busy, o_instr_count},
          {e.stg, e.en, e.st, e.busy, CW'(e.cnt)});
    obs_mem  += int'(o_mem_en);
    obs_wb   += int'(o_wb_en);
    obs_pc   += int'(o_pc_en);
    obs_cc   += int'(o_set_cc);
    obs_busy += int'(o_busy);
  endtask

  task automatic run_plan();
    for (int k = 0; k < plan.size(); k++) begin
      @(posedge clk); #1;
      drive(plan[k]);
      @(negedge clk);
      check_cycle(k, plan[k]);
    end
    @(posedge clk); #1;
  endtask

  task automatic begin_scn();
    rst = 1'b1; start = 1'b0; ie = 1'b0; rdy = 1'b0; derr = 1'b0; ic = 4'd0;
`ifdef SEQ_SINGLE_STEP_EN
    step = 1'b0;
`endif
    @(posedge clk); #1;
    check("reset_state",
          {o_stage, o_fetch_en, o_decode_en, o_exec_en, o_set_cc, o_mem_en, o_wb_en,
           o_pc_en, o_busy, o_stat, o_instr_count},
          {3'd0, 7'd0, 1'b0, 3'd1, 3'd0});
    @(negedge clk);
    rst = 1'b0;
    plan.delete();
    m_cnt = 0; m_stat = 3'd1; m_halted = 1'b0; m_need_step = 1'b0;
    add_idle();
  endtask

  int b_mem, b_wb, b_pc, b_cc, b_busy;
  task automatic snap();
    b_mem = obs_mem; b_wb = obs_wb; b_pc = obs_pc; b_cc = obs_cc; b_busy = obs_busy;
  endtask

  initial begin
    // OPq with ready tied high, then reset in the middle of EXECUTE
    begin_scn(); add_instr(4'd6, 0, 0, 0); snap(); run_plan();
    check("opq_cycles", obs_busy - b_busy, 6);
    check("opq_setcc", obs_cc - b_cc, 1);
    check("opq_mem_en", obs_mem - b_mem, 0);
    check("opq_count", o_instr_count, 1);
    check("opq_stat", o_stat, 1);
`ifdef SEQ_SINGLE_STEP_EN
    step = 1'b1; @(posedge clk); #1; step = 1'b0;
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_exec", {o_stage, o_exec_en, o_set_cc}, {3'd3, 1'b1, 1'b1});
    rst = 1'b1; #1;
    check("rst_mid_exec",
          {o_stage, o_fetch_en, o_decode_en, o_exec_en, o_set_cc, o_mem_en, o_wb_en,
           o_pc_en, o_busy, o_stat, o_instr_count},
          {3'd0, 7'd0, 1'b0, 3'd1, 3'd0});

    // mrmovq, ready 3 cycles after MEMORY entry
    begin_scn(); add_instr(4'd5, 0, 3, 0); snap(); run_plan();
    check("mrm_mem_en", obs_mem - b_mem, 4);
    check("mrm_cycles", obs_busy - b_busy, 9);
    check("mrm_count", o_instr_count, 1);

    // rmmovq, ready never arrives
    begin_scn(); add_instr(4'd4, 0, -1, 0); add_tail(3); snap(); run_plan();
    check("to_mem_en", obs_mem - b_mem, TO);
    check("to_wb_pc", (obs_wb - b_wb) + (obs_pc - b_pc), 0);
    check("to_stat", o_stat, 3);

    // halt instruction, start pulses ignored afterwards
    begin_scn(); add_instr(4'd0, 0, 0, 0); add_tail(4); snap(); run_plan();
    check("hlt_pc", obs_pc - b_pc, 0);
    check("hlt_stat_busy", {o_stage, o_stat, o_busy}, {3'd7, 3'd2, 1'b0});

    // invalid icodes, imem fault, dmem fault
    begin_scn(); add_instr(4'd12, 0, 0, 0); add_tail(2); run_plan();
    check("ins12_stat", o_stat, 4);
    begin_scn(); add_instr(4'd15, 0, 0, 0); add_tail(2); run_plan();
    begin_scn(); add_instr(4'd6, 1, 0, 0); add_tail(2); run_plan();
    check("imem_stat", o_stat, 3);
    begin_scn(); add_instr(4'd5, 0, 2, 1); add_tail(2); run_plan();
    check("dmem_err_stat", o_stat, 3);

    // mixed program: counter wraps, ready on the timeout cycle wins, then timeout
    begin_scn();
    add_instr(4'd6, 0, 0, 0);  add_instr(4'd1, 0, 0, 0);  add_instr(4'd5, 0, 3, 0);
    add_instr(4'd4, 0, 0, 0);  add_instr(4'd2, 0, 0, 0);  add_instr(4'd3, 0, 0, 0);
    add_instr(4'd7, 0, 0, 0);  add_instr(4'd8, 0, 1, 0);  add_instr(4'd9, 0, TO - 1, 0);
    add_instr(4'd10, 0, 0, 0); add_instr(4'd11, 0, 0, 0);
    add_instr(4'd4, 0, -1, 0); add_tail(3);
    run_plan();
    check("prog_count_wrap", o_instr_count, 3);
    check("prog_stat", o_stat, 3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
